axis_data_router: RTL and testbench
===================================

# axis_data_router

Routes one AXI4-Stream input to one of two AXI4-Stream outputs under control of a select line; this is the demultiplexing counterpart of the two-input data switch in the signal chain. Route changes are applied only on packet boundaries, after the previously selected output has drained, so no packet is ever split across outputs. Each output carries a one-entry register slice, giving full throughput with one cycle of latency.

## Interface
- DATA_WIDTH, 16, tdata width in bits of the input and both outputs.
- aclk  in  1  clock, all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- sel  in  1  requested route: 0 selects m0, 1 selects m1. Synchronous to aclk.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tready  out  1  input ready.
- m0_axis_tdata  out  DATA_WIDTH  output 0 data.
- m0_axis_tvalid  out  1  output 0 valid.
- m0_axis_tlast  out  1  output 0 end of packet.
- m0_axis_tready  in  1  output 0 ready.
- m1_axis_tdata, m1_axis_tvalid, m1_axis_tlast, m1_axis_tready: same as m0 for output 1.
- active_route  out  1  route currently in effect.

## Operation
- Internal registers: route (1 bit), in_packet (1 bit), state ∈ {PASS, DRAIN}.
- in_packet is set on an accepted input beat with tlast=0 and cleared on an accepted beat with tlast=1.
- switch_req = (sel != route) && !in_packet.
- PASS state:
  - s_axis_tready = !switch_req && (!mR_tvalid || mR_tready), where R = route.
  - An accepted beat loads the slice of output R; the other slice is untouched.
  - If switch_req is true, go to DRAIN on the next edge.
- DRAIN state:
  - s_axis_tready = 0.
  - When the slice of output R is empty, or is being emptied this cycle: route <= sel and state returns to PASS.
  - If sel flips back to equal route while in DRAIN, return to PASS without changing route.
- Slice rule per output: tvalid is set on load and cleared on tready && !load. Load and unload in the same cycle replaces the data with no bubble.
- active_route = route.

## Timing
- Reset values: all m*_axis_tvalid = 0, all tdata/tlast = 0, s_axis_tready = 0 while reset is asserted, route = 0, in_packet = 0, state = PASS.
- Reset asserted mid-packet discards all in-flight data immediately; after release, routing restarts on m0.
- Latency: input beat accepted at edge N appears on mR_axis at edge N (registered output), visible in cycle N+1.
- Throughput: 1 beat per cycle while the selected output holds tready = 1.
- Route change with the old slice empty: 2 cycles of s_axis_tready = 0 (one cycle of switch_req in PASS, one in DRAIN); the first beat on the new output is accepted in the third cycle.
- Route change with the old slice full: the DRAIN state extends until the old output accepts its beat.
- A change of sel during a packet takes effect only after the tlast beat is accepted.
- The non-selected output holds its tvalid until that beat is consumed; that output's backpressure never stalls the selected route.

## Configuration
- AXIS_DATA_ROUTER_BEAT_COUNT_EN:
  - Defined: adds outputs beat_count0 and beat_count1 (32 bits each). Each counts beats accepted on its m*_axis interface (tvalid && tready), resets to 0, and wraps from 2^32-1 to 0.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package axis_data_router_pkg holds:
  - state_t enum {PASS, DRAIN};
  - route constants ROUTE_M0 = 1'b0 and ROUTE_M1 = 1'b1;
  - BEAT_COUNT_W = 32.
- Sub-module axis_out_slice: a one-entry register slice with DATA_WIDTH data plus tlast, load/tready input, and asynchronous active-low reset. It is instantiated once per output.

## Test plan
- Reset release with sel = 0; send 4-beat packet 14, 15, 16, 17 (tlast on 17), m0_tready = 1 -> m0 emits 14..17 on consecutive cycles, one-cycle latency; m1_tvalid stays 0.
- Set sel = 1 mid-packet, at beat 2 of a 4-beat packet -> all 4 beats go to m0; s_axis_tready is low 2 cycles after tlast; the next packet (-29, 7) appears on m1; active_route becomes 1.
- Hold m0_tready = 0 with one beat in the m0 slice, then request sel = 1 -> DRAIN persists until m0_tready = 1; m1 receives no data before the m0 beat is accepted.
- Single-beat packets (tlast = 1 on every beat) with sel toggling every packet -> packets alternate between m0 and m1 with no loss, no duplication, and order preserved per output.
- Assert aresetn low while m1 holds a beat -> m1_tvalid drops to 0 asynchronously; after release, data routes to m0 regardless of prior route.
- With AXIS_DATA_ROUTER_BEAT_COUNT_EN defined, preload beat_count0 to 2^32-2 via a force, then send 3 beats to m0 -> beat_count0 reads 1 and beat_count1 is unchanged.

Source files
------------

// File: rtl/axis_data_router_pkg.sv
// Shared types and constants for the AXI4-Stream 1-to-2 data router.
package axis_data_router_pkg;

    typedef enum logic {
        PASS  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic ROUTE_M0     = 1'b0;
    localparam logic ROUTE_M1     = 1'b1;
    localparam int   BEAT_COUNT_W = 32;

endpackage

// File: rtl/axis_data_router_out_slice.sv
// One-entry AXI4-Stream register slice: load and unload in the same cycle
// replace the held beat without a bubble.
module axis_out_slice #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    output logic                  tlast,
    input  logic                  tready
);

    logic [DATA_WIDTH-1:0] data_p0;
    logic                  last_p0;
    logic                  vld_p0;

    // Stage p0: the single holding register presented on the output
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_p0 <= '0;
            last_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end else if (load) begin
            data_p0 <= load_data;
            last_p0 <= load_last;
            vld_p0  <= 1'b1;
        end else if (tready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign tdata  = data_p0;
    assign tlast  = last_p0;
    assign tvalid = vld_p0;

endmodule

// File: rtl/axis_data_router.sv
// Routes one AXI4-Stream input to m0 or m1; the route only changes between
// packets once the old output slice has drained.
// Optional per-output beat counters: define AXIS_DATA_ROUTER_BEAT_COUNT_EN.
module axis_data_router
    import axis_data_router_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    sel,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m0_axis_tdata,
    output logic                    m0_axis_tvalid,
    output logic                    m0_axis_tlast,
    input  logic                    m0_axis_tready,
    output logic [DATA_WIDTH-1:0]   m1_axis_tdata,
    output logic                    m1_axis_tvalid,
    output logic                    m1_axis_tlast,
    input  logic                    m1_axis_tready,
    output logic                    active_route
`ifdef AXIS_DATA_ROUTER_BEAT_COUNT_EN
    ,
    output logic [BEAT_COUNT_W-1:0] beat_count0,
    output logic [BEAT_COUNT_W-1:0] beat_count1
`endif
);

    state_t state_q, state_d;
    logic   route_q, route_d;
    logic   in_packet_q;
    logic   switch_req;
    logic   cur_tvalid, cur_tready, cur_free;
    logic   accept, load0, load1;

    assign cur_tvalid = (route_q == ROUTE_M1) ? m1_axis_tvalid : m0_axis_tvalid;
    assign cur_tready = (route_q == ROUTE_M1) ? m1_axis_tready : m0_axis_tready;
    // Current slice can take a beat if empty or emptying this cycle
    assign cur_free   = !cur_tvalid || cur_tready;
    assign switch_req = (sel != route_q) && !in_packet_q;

    always_comb begin
        state_d       = state_q;
        route_d       = route_q;
        s_axis_tready = 1'b0;
        case (state_q)
            PASS: begin
                s_axis_tready = aresetn && !switch_req && cur_free;
                if (switch_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (sel == route_q) begin
                    state_d = PASS;
                end else if (cur_free) begin
                    route_d = sel;
                    state_d = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    assign accept = s_axis_tvalid && s_axis_tready;
    assign load0  = accept && (route_q == ROUTE_M0);
    assign load1  = accept && (route_q == ROUTE_M1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= PASS;
            route_q     <= ROUTE_M0;
            in_packet_q <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            if (accept) in_packet_q <= !s_axis_tlast;
        end
    end

    assign active_route = route_q;

    axis_out_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice0 (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (load0),
        .load_data (s_axis_tdata),
        .load_last (s_axis_tlast),
        .tdata     (m0_axis_tdata),
        .tvalid    (m0_axis_tvalid),
        .tlast     (m0_axis_tlast),
        .tready    (m0_axis_tready)
    );

    axis_out_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice1 (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (load1),
        .load_data (s_axis_tdata),
        .load_last (s_axis_tlast),
        .tdata     (m1_axis_tdata),
        .tvalid    (m1_axis_tvalid),
        .tlast     (m1_axis_tlast),
        .tready    (m1_axis_tready)
    );

`ifdef AXIS_DATA_ROUTER_BEAT_COUNT_EN
    // Counters wrap naturally at 2^BEAT_COUNT_W
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_count0 <= '0;
            beat_count1 <= '0;
        end else begin
            if (m0_axis_tvalid && m0_axis_tready) beat_count0 <= beat_count0 + BEAT_COUNT_W'(1);
            if (m1_axis_tvalid && m1_axis_tready) beat_count1 <= beat_count1 + BEAT_COUNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_axis_data_router.sv
// Scoreboard bench for axis_data_router: directed packets push expected beats
// per output; a negedge monitor pops and compares every output handshake.
module tb_axis_data_router;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [15:0] m0_axis_tdata, m1_axis_tdata;
    logic        m0_axis_tvalid, m0_axis_tlast, m1_axis_tvalid, m1_axis_tlast;
    logic        m0_axis_tready = 1'b1;
    logic        m1_axis_tready = 1'b1;
    logic        active_route;
`ifdef AXIS_DATA_ROUTER_BEAT_COUNT_EN
    logic [31:0] beat_count0, beat_count1;
`endif

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    axis_data_router #(.DATA_WIDTH(16)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .sel            (sel),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .m0_axis_tdata  (m0_axis_tdata),
        .m0_axis_tvalid (m0_axis_tvalid),
        .m0_axis_tlast  (m0_axis_tlast),
        .m0_axis_tready (m0_axis_tready),
        .m1_axis_tdata  (m1_axis_tdata),
        .m1_axis_tvalid (m1_axis_tvalid),
        .m1_axis_tlast  (m1_axis_tlast),
        .m1_axis_tready (m1_axis_tready),
        .active_route   (active_route)
`ifdef AXIS_DATA_ROUTER_BEAT_COUNT_EN
        ,
        .beat_count0    (beat_count0),
        .beat_count1    (beat_count1)
`endif
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: a beat with tvalid && tready at the negedge transfers on the next posedge
    always @(negedge aclk) begin
        exp_t e;
        if (aresetn) begin
            if (m0_axis_tvalid && m0_axis_tready) begin
                if (exp_q0.size() == 0) begin
                    check("m0 unexpected beat", 32'(m0_axis_tdata), 32'hDEAD_0000);
                end else begin
                    e = exp_q0.pop_front();
                    check("m0 tdata", 32'(m0_axis_tdata), 32'(e.data));
                    check("m0 tlast", 32'(m0_axis_tlast), 32'(e.last));
                end
            end
            if (m1_axis_tvalid && m1_axis_tready) begin
                if (exp_q1.size() == 0) begin
                    check("m1 unexpected beat", 32'(m1_axis_tdata), 32'hDEAD_0001);
                end else begin
                    e = exp_q1.pop_front();
                    check("m1 tdata", 32'(m1_axis_tdata), 32'(e.data));
                    check("m1 tlast", 32'(m1_axis_tlast), 32'(e.last));
                end
            end
        end
    end

    // Issue one beat expected on output 'port'; returns at posedge+1 after acceptance
    task automatic send(input logic [15:0] d, input logic l, input logic port, output int stalls);
        exp_t e;
        int   n;
        e.data = d;
        e.last = l;
        if (port) exp_q1.push_back(e);
        else      exp_q0.push_back(e);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        stalls = 0;
        n = 0;
        @(negedge aclk);
        while (!s_axis_tready && n < 50) begin
            stalls++;
            n++;
            @(negedge aclk);
        end
        if (n >= 50) check("s_axis_tready timeout", 32'(n), 32'd0);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        int st;
        int c0;

        // Reset state
        repeat (3) @(negedge aclk);
        check("reset m0_tvalid", 32'(m0_axis_tvalid), 32'd0);
        check("reset m1_tvalid", 32'(m1_axis_tvalid), 32'd0);
        check("reset m0_tdata", 32'(m0_axis_tdata), 32'd0);
        check("reset s_tready", 32'(s_axis_tready), 32'd0);
        check("reset active_route", 32'(active_route), 32'd0);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // Packet 14..17 to m0: one-cycle latency, full throughput
        c0 = cyc;
        send(16'd14, 1'b0, 1'b0, st);
        check("latency m0_tvalid", 32'(m0_axis_tvalid), 32'd1);
        check("latency m0_tdata", 32'(m0_axis_tdata), 32'd14);
        send(16'd15, 1'b0, 1'b0, st);
        send(16'd16, 1'b0, 1'b0, st);
        send(16'd17, 1'b1, 1'b0, st);
        check("throughput cycles", 32'(cyc - c0), 32'd4);
        check("m1_tvalid idle", 32'(m1_axis_tvalid), 32'd0);

        // sel changes mid-packet: switch only after tlast, 2 stall cycles
        send(16'd20, 1'b0, 1'b0, st);
        send(16'd21, 1'b0, 1'b0, st);
        sel = 1'b1;
        send(16'd22, 1'b0, 1'b0, st);
        check("mid-packet stall", 32'(st), 32'd0);
        send(16'd23, 1'b1, 1'b0, st);
        send(16'hFFE3, 1'b0, 1'b1, st);
        check("switch stalls", 32'(st), 32'd2);
        send(16'd7, 1'b1, 1'b1, st);
        check("active_route m1", 32'(active_route), 32'd1);

        // Old slice blocked: DRAIN lasts until m0 takes its beat
        m0_axis_tready = 1'b0;
        sel = 1'b0;
        send(16'h0055, 1'b1, 1'b0, st);
        check("switch back stalls", 32'(st), 32'd2);
        sel = 1'b1;
        fork
            send(16'h0066, 1'b1, 1'b1, st);
            begin
                repeat (5) @(posedge aclk);
                #1 m0_axis_tready = 1'b1;
            end
        join
        check("blocked drain stalls", 32'(st), 32'd6);

        // Single-beat packets alternating route
        for (int i = 0; i < 6; i++) begin
            sel = i[0];
            send(16'h0100 + 16'(i), 1'b1, i[0], st);
            check("alternate stalls", 32'(st), 32'd2);
        end

        // Reset while m1 holds a beat
        idle(3);
        m1_axis_tready = 1'b0;
        send(16'h0077, 1'b1, 1'b1, st);
        idle(2);
        check("m1 holding", 32'(m1_axis_tvalid), 32'd1);
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check("async reset m1_tvalid", 32'(m1_axis_tvalid), 32'd0);
        check("reset s_tready low", 32'(s_axis_tready), 32'd0);
        exp_q1.delete();
        sel = 1'b0;
        m1_axis_tready = 1'b1;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        check("post-reset route", 32'(active_route), 32'd0);
        send(16'h0088, 1'b1, 1'b0, st);
        check("post-reset stalls", 32'(st), 32'd0);

`ifdef AXIS_DATA_ROUTER_BEAT_COUNT_EN
        idle(3);
        force dut.beat_count0 = 32'hFFFF_FFFE;
        force dut.beat_count1 = 32'd5;
        #1;
        release dut.beat_count0;
        release dut.beat_count1;
        send(16'd1, 1'b0, 1'b0, st);
        send(16'd2, 1'b0, 1'b0, st);
        send(16'd3, 1'b1, 1'b0, st);
        idle(3);
        check("beat_count0 wrap", beat_count0, 32'd1);
        check("beat_count1 hold", beat_count1, 32'd5);
`endif

        idle(5);
        check("m0 queue drained", 32'(exp_q0.size()), 32'd0);
        check("m1 queue drained", 32'(exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
